// File: rtl/sdram_arb_pkg.sv
// Shared types and constants for the two-port SDRAM arbiter.
package sdram_arb_pkg;
  localparam int AddrWidth = 25;
  localparam int DataWidth = 16;
  localparam int NumPorts  = 2;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_WRITE = 2'd1,
    ST_READ  = 2'd2
  } state_t;

  localparam logic [1:0] CMD_IDLE  = 2'd0;
  localparam logic [1:0] CMD_WRITE = 2'd1;
  localparam logic [1:0] CMD_READ  = 2'd2;
endpackage

// File: rtl/sdram_port_arbiter_if.sv
// Bundle of requester-side and controller-side signals around the arbiter.
interface sdram_port_arbiter_if import sdram_arb_pkg::*; ();
  logic [NumPorts-1:0]                p_req_i;
  logic [NumPorts-1:0]                p_we_i;
  logic [NumPorts-1:0][AddrWidth-1:0] p_addr_i;
  logic [NumPorts-1:0][DataWidth-1:0] p_wdata_i;
  logic [NumPorts-1:0]                p_ack_o;
  logic [DataWidth-1:0]               p_rdata_o;
  logic [NumPorts-1:0]                p_rvalid_o;
  logic [1:0]                         sd_cmd_o;
  logic [AddrWidth-1:0]               sd_addr_o;
  logic [DataWidth-1:0]               sd_wdata_o;
  logic [DataWidth-1:0]               sd_rdata_i;
  logic                               sd_rvalid_i;
  logic                               sd_wdone_i;

  modport slave (
    input  p_req_i, p_we_i, p_addr_i, p_wdata_i,
    output p_ack_o, p_rdata_o, p_rvalid_o,
    output sd_cmd_o, sd_addr_o, sd_wdata_o,
    input  sd_rdata_i, sd_rvalid_i, sd_wdone_i
  );

  modport master (
    output p_req_i, p_we_i, p_addr_i, p_wdata_i,
    input  p_ack_o, p_rdata_o, p_rvalid_o,
    input  sd_cmd_o, sd_addr_o, sd_wdata_o,
    output sd_rdata_i, sd_rvalid_i, sd_wdone_i
  );
endinterface

// File: rtl/rr_arb2.sv
// Combinational two-way round-robin grant: on conflict the port not granted last wins.
module rr_arb2 (
  input  logic [1:0] req,
  input  logic       last,
  output logic [1:0] grant
);
  logic winner;

  always_comb begin
    winner = (req == 2'b11) ? ~last : req[1];
    grant  = 2'b00;
    if (req != 2'b00) begin
      grant = winner ? 2'b10 : 2'b01;
    end
  end
endmodule

// File: rtl/sdram_port_arbiter.sv
// Two-port arbiter in front of an SDRAM controller: one transaction at a time,
// round-robin grant, read beats passed straight through to the owning port.
module sdram_port_arbiter import sdram_arb_pkg::*; #(
  parameter int ReadBurstLength = 1
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  sdram_port_arbiter_if.slave  bus
);
  localparam int BeatWidth = $clog2(ReadBurstLength) + 1;
  localparam logic [BeatWidth-1:0] LastBeat = BeatWidth'(ReadBurstLength);

  state_t               state_reg, state_next;
  logic                 owner_reg, owner_next;
  logic                 last_reg, last_next;
  logic [BeatWidth-1:0] beat_reg, beat_next, beat_inc;
  logic [1:0]           cmd_reg, cmd_next;
  logic [AddrWidth-1:0] addr_reg, addr_next;
  logic [DataWidth-1:0] wdata_reg, wdata_next;
  logic [NumPorts-1:0]  grant, ack, rvalid;

  rr_arb2 u_rr_arb2 (
    .req   (bus.p_req_i),
    .last  (last_reg),
    .grant (grant)
  );

  // last_reg resets to port 1 so that port 0 wins the first conflict.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_reg <= ST_IDLE;
      owner_reg <= 1'b0;
      last_reg  <= 1'b1;
      beat_reg  <= '0;
      cmd_reg   <= CMD_IDLE;
      addr_reg  <= '0;
      wdata_reg <= '0;
    end else begin
      state_reg <= state_next;
      owner_reg <= owner_next;
      last_reg  <= last_next;
      beat_reg  <= beat_next;
      cmd_reg   <= cmd_next;
      addr_reg  <= addr_next;
      wdata_reg <= wdata_next;
    end
  end

  assign beat_inc = beat_reg + 1'b1;

  always_comb begin
    state_next = state_reg;
    owner_next = owner_reg;
    last_next  = last_reg;
    beat_next  = beat_reg;
    cmd_next   = cmd_reg;
    addr_next  = addr_reg;
    wdata_next = wdata_reg;
    ack        = '0;
    rvalid     = '0;
    case (state_reg)
      ST_IDLE: begin
        if (grant != 2'b00) begin
          owner_next = grant[1];
          last_next  = grant[1];
          beat_next  = '0;
          addr_next  = bus.p_addr_i[grant[1]];
          wdata_next = bus.p_wdata_i[grant[1]];
          if (bus.p_we_i[grant[1]]) begin
            state_next = ST_WRITE;
            cmd_next   = CMD_WRITE;
          end else begin
            state_next = ST_READ;
            cmd_next   = CMD_READ;
          end
        end
      end
      ST_WRITE: begin
        if (bus.sd_wdone_i) begin
          ack[owner_reg] = 1'b1;
          state_next     = ST_IDLE;
          cmd_next       = CMD_IDLE;
        end
      end
      ST_READ: begin
        // The read command is dropped once the controller has started returning beats.
        if (bus.sd_rvalid_i) begin
          rvalid[owner_reg] = 1'b1;
          cmd_next          = CMD_IDLE;
          beat_next         = beat_inc;
          if (beat_inc == LastBeat) begin
            ack[owner_reg] = 1'b1;
            state_next     = ST_IDLE;
          end
        end
      end
      default: begin
        state_next = ST_IDLE;
        cmd_next   = CMD_IDLE;
      end
    endcase
  end

  // Strobes are suppressed during reset so an abandoned transaction never completes.
  assign bus.p_ack_o    = rst_i ? '0 : ack;
  assign bus.p_rvalid_o = rst_i ? '0 : rvalid;
  assign bus.p_rdata_o  = bus.sd_rdata_i;
  assign bus.sd_cmd_o   = cmd_reg;
  assign bus.sd_addr_o  = addr_reg;
  assign bus.sd_wdata_o = wdata_reg;
endmodule

// File: tb/tb_sdram_port_arbiter.sv
// Directed bench for sdram_port_arbiter with a queue-based scoreboard on port strobes.
module tb_sdram_port_arbiter;
  import sdram_arb_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  sdram_port_arbiter_if bus ();

  sdram_port_arbiter #(.ReadBurstLength(4)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  int chk_cnt  = 0;
  int pass_cnt = 0;
  logic [19:0] exp_q[$];
  logic [19:0] obs, exp_v;

  localparam logic [24:0] A0 = 25'h0000A0A;
  localparam logic [24:0] A1 = 25'h1F0F0F0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic expect_evt(input logic [1:0] a, input logic [1:0] rv, input logic [15:0] d);
    exp_q.push_back({a, rv, d});
  endtask

  // Monitor: every cycle with a port strobe must match the next scoreboard entry.
  always @(negedge clk) begin
    if (bus.p_ack_o !== 2'b00 || bus.p_rvalid_o !== 2'b00) begin
      obs = {bus.p_ack_o, bus.p_rvalid_o, (bus.p_rvalid_o != 2'b00) ? bus.p_rdata_o : 16'h0};
      $display("txn t=%0t ack=%b rvalid=%b rdata=0x%h", $time, bus.p_ack_o, bus.p_rvalid_o, bus.p_rdata_o);
      if (exp_q.size() == 0) begin
        check("unexpected_strobe", 32'(obs), 32'h0);
      end else begin
        exp_v = exp_q.pop_front();
        check("port_event", 32'(obs), 32'(exp_v));
      end
    end
  end

  initial begin
    bus.p_req_i     = '0;
    bus.p_we_i      = '0;
    bus.p_addr_i    = '0;
    bus.p_wdata_i   = '0;
    bus.sd_rdata_i  = '0;
    bus.sd_rvalid_i = 1'b0;
    bus.sd_wdone_i  = 1'b0;
    rst = 1'b1;
    repeat (3) tick();
    check("rst_cmd", 32'(bus.sd_cmd_o), 32'(CMD_IDLE));
    check("rst_addr", 32'(bus.sd_addr_o), 32'h0);
    check("rst_wdata", 32'(bus.sd_wdata_o), 32'h0);
    check("rst_ack", 32'(bus.p_ack_o), 32'h0);
    check("rst_rvalid", 32'(bus.p_rvalid_o), 32'h0);
    rst = 1'b0;
    tick();

    // Single write on port 0
    bus.p_req_i = 2'b01;
    bus.p_we_i  = 2'b01;
    bus.p_addr_i[0]  = 25'h0000123;
    bus.p_wdata_i[0] = 16'hBEEF;
    tick();
    check("wr_cmd_latency", 32'(bus.sd_cmd_o), 32'(CMD_WRITE));
    check("wr_addr", 32'(bus.sd_addr_o), 32'h0000123);
    check("wr_wdata", 32'(bus.sd_wdata_o), 32'hBEEF);
    repeat (4) begin
      tick();
      check("wr_cmd_hold", 32'(bus.sd_cmd_o), 32'(CMD_WRITE));
    end
    bus.sd_wdone_i = 1'b1;
    expect_evt(2'b01, 2'b00, 16'h0);
    tick();
    bus.sd_wdone_i = 1'b0;
    bus.p_req_i    = 2'b00;
    check("wr_cmd_clear", 32'(bus.sd_cmd_o), 32'(CMD_IDLE));
    tick();
    check("wr_idle", 32'(bus.sd_cmd_o), 32'(CMD_IDLE));

    // Burst read of 4 on port 1; requester drops req after the first beat
    bus.p_req_i = 2'b10;
    bus.p_we_i  = 2'b00;
    bus.p_addr_i[1] = 25'h1000000;
    tick();
    check("rd_cmd_latency", 32'(bus.sd_cmd_o), 32'(CMD_READ));
    check("rd_addr", 32'(bus.sd_addr_o), 32'h1000000);
    tick();
    check("rd_cmd_hold", 32'(bus.sd_cmd_o), 32'(CMD_READ));
    for (int i = 1; i <= 4; i++) begin
      bus.sd_rvalid_i = 1'b1;
      bus.sd_rdata_i  = 16'(i);
      expect_evt((i == 4) ? 2'b10 : 2'b00, 2'b10, 16'(i));
      tick();
      if (i == 1) begin
        check("rd_cmd_after_beat1", 32'(bus.sd_cmd_o), 32'(CMD_IDLE));
        bus.p_req_i = 2'b00;
      end
    end
    bus.sd_rvalid_i = 1'b0;
    tick();
    check("rd_idle", 32'(bus.sd_cmd_o), 32'(CMD_IDLE));

    // Spurious controller responses while idle
    bus.sd_rvalid_i = 1'b1;
    bus.sd_wdone_i  = 1'b1;
    bus.sd_rdata_i  = 16'hDEAD;
    #2;
    check("spur_ack", 32'(bus.p_ack_o), 32'h0);
    check("spur_rvalid", 32'(bus.p_rvalid_o), 32'h0);
    tick();
    tick();
    bus.sd_rvalid_i = 1'b0;
    bus.sd_wdone_i  = 1'b0;
    check("spur_cmd", 32'(bus.sd_cmd_o), 32'(CMD_IDLE));

    // Contention after reset: grants alternate 0,1,0,1 with an idle gap
    rst = 1'b1;
    tick();
    rst = 1'b0;
    bus.p_req_i = 2'b11;
    bus.p_we_i  = 2'b11;
    bus.p_addr_i[0] = A0;
    bus.p_addr_i[1] = A1;
    bus.p_wdata_i[0] = 16'h1111;
    bus.p_wdata_i[1] = 16'h2222;
    tick();
    for (int k = 0; k < 4; k++) begin
      check("cont_cmd", 32'(bus.sd_cmd_o), 32'(CMD_WRITE));
      check("cont_addr", 32'(bus.sd_addr_o), 32'((k % 2 == 1) ? A1 : A0));
      tick();
      bus.sd_wdone_i = 1'b1;
      expect_evt((k % 2 == 1) ? 2'b10 : 2'b01, 2'b00, 16'h0);
      tick();
      bus.sd_wdone_i = 1'b0;
      if (k == 3) bus.p_req_i = 2'b00;
      check("cont_gap", 32'(bus.sd_cmd_o), 32'(CMD_IDLE));
      tick();
    end
    check("cont_end_idle", 32'(bus.sd_cmd_o), 32'(CMD_IDLE));

    // Reset in the middle of a 4-beat read on port 0
    bus.p_req_i = 2'b01;
    bus.p_we_i  = 2'b00;
    bus.p_addr_i[0] = 25'h0ABCDEF;
    tick();
    check("rstrd_cmd", 32'(bus.sd_cmd_o), 32'(CMD_READ));
    for (int i = 1; i <= 2; i++) begin
      bus.sd_rvalid_i = 1'b1;
      bus.sd_rdata_i  = 16'h0010 + 16'(i);
      expect_evt(2'b00, 2'b01, 16'h0010 + 16'(i));
      tick();
    end
    rst = 1'b1;
    bus.p_req_i    = 2'b00;
    bus.sd_rdata_i = 16'h0013;
    tick();
    check("rstrd_cmd_cleared", 32'(bus.sd_cmd_o), 32'(CMD_IDLE));
    check("rstrd_addr_cleared", 32'(bus.sd_addr_o), 32'h0);
    bus.sd_rdata_i = 16'h0014;
    tick();
    rst = 1'b0;
    bus.sd_rdata_i = 16'h0015;
    #2;
    check("rstrd_late_rvalid", 32'(bus.p_rvalid_o), 32'h0);
    check("rstrd_late_ack", 32'(bus.p_ack_o), 32'h0);
    tick();
    bus.sd_rvalid_i = 1'b0;
    bus.p_req_i = 2'b11;
    bus.p_we_i  = 2'b11;
    bus.p_addr_i[0] = A0;
    tick();
    check("rstrd_rr_cmd", 32'(bus.sd_cmd_o), 32'(CMD_WRITE));
    check("rstrd_rr_port0", 32'(bus.sd_addr_o), 32'(A0));
    bus.sd_wdone_i = 1'b1;
    expect_evt(2'b01, 2'b00, 16'h0);
    tick();
    bus.sd_wdone_i = 1'b0;
    bus.p_req_i    = 2'b00;
    tick();
    tick();

    check("queue_drained", 32'(exp_q.size()), 32'h0);
    $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
    $finish;
  end
endmodule

// File: doc/sdram_port_arbiter.md
SDRAM_PORT_ARBITER -- requirements
Module: sdram_port_arbiter

Interface
REQ-001 Parameter ReadBurstLength, default 1, SHALL set the number of read beats per read transaction (1, 2, 4 or 8).
REQ-002 clk_i  input  1  sole clock; all logic SHALL be rising-edge.
REQ-003 rst_i  input  1  SHALL be a synchronous, active-high reset.
REQ-004 p_req_i  input  2  per-port request; port p is held high until p_ack_o[p].
REQ-005 p_we_i  input  2  per-port direction: 1 = write, 0 = read.
REQ-006 p_addr_i  input  2x25  per-port {bank, row, column} address.
REQ-007 p_wdata_i  input  2x16  per-port write data.
REQ-008 p_ack_o  output  2  one-cycle pulse at transaction completion for the owning port.
REQ-009 p_rdata_o  output  16  read data, shared bus.
REQ-010 p_rvalid_o  output  2  per-port read-beat strobe.
REQ-011 sd_cmd_o  output  2  controller command: 0 idle, 1 write, 2 read.
REQ-012 sd_addr_o  output  25  controller address.
REQ-013 sd_wdata_o  output  16  controller write data.
REQ-014 sd_rdata_i  input  16  controller read data.
REQ-015 sd_rvalid_i  input  1  controller read-beat valid.
REQ-016 sd_wdone_i  input  1  controller write-done pulse.

Function
REQ-017 The FSM SHALL have three states:
- IDLE
- WRITE
- READ
REQ-018 In IDLE with any p_req_i set, the arbiter SHALL grant one port and, on the next edge, enter WRITE or READ per that port's p_we_i.
- On grant, it SHALL register the port's address and data into sd_addr_o/sd_wdata_o.
REQ-019 Arbitration SHALL be round-robin.
- The port not most recently granted wins on conflict.
- A lone requester wins immediately.
- After reset, port 0 has priority.
REQ-020 In WRITE, sd_cmd_o SHALL hold 1 until sd_wdone_i is sampled high.
- Same cycle: pulse p_ack_o[owner] and return to IDLE; sd_cmd_o = 0 the following cycle.
REQ-021 In READ, sd_cmd_o SHALL hold 2 until the first sd_rvalid_i, then drive 0.
REQ-022 In READ, a beat counter SHALL count sd_rvalid_i beats.
- Each beat: p_rdata_o = sd_rdata_i and p_rvalid_o[owner] = 1, both combinational pass-through (zero latency).
- On beat ReadBurstLength: pulse p_ack_o[owner] with that beat and return to IDLE.
REQ-023 Latency from p_req_i rise on an idle arbiter to sd_cmd_o nonzero SHALL be exactly 1 cycle.
REQ-024 A new grant SHALL NOT occur in the same cycle as p_ack_o.
- Minimum one IDLE cycle between transactions, giving the controller's auto-precharge a command gap.
REQ-025 sd_rvalid_i or sd_wdone_i arriving in IDLE or in the wrong state SHALL be ignored.
- No p_rvalid_o, no p_ack_o, no state change.
REQ-026 p_rvalid_o and p_ack_o SHALL only ever assert for the owner port, never both bits at once.
REQ-027 A requester dropping p_req_i mid-transaction SHALL NOT abort it; completion still pulses p_ack_o.
REQ-028 The beat counter SHALL be clog2(ReadBurstLength)+1 bits and SHALL clear on every grant.

Reset
REQ-029 While rst_i is high, at every edge:
- state = IDLE
- sd_cmd_o = 0, sd_addr_o = 0, sd_wdata_o = 0
- p_ack_o = 0, p_rvalid_o = 0
- beat counter = 0
- round-robin pointer = port 0 priority
REQ-030 Reset asserted mid-transaction SHALL abandon it without p_ack_o.
- Controller responses arriving after reset SHALL be ignored per REQ-025.

Structure
REQ-031 Shared package sdram_arb_pkg SHALL hold:
- the state enum
- command encodings (CMD_IDLE = 0, CMD_WRITE = 1, CMD_READ = 2)
- AddrWidth = 25 and DataWidth = 16
REQ-032 Round-robin grant logic SHALL be a sub-module rr_arb2: combinational 2-way grant from request vector and last-grant bit.

Verification
REQ-033 Single write: reset, port0 req we=1 addr=0x0000123 data=0xBEEF; sd_wdone_i 5 cycles after sd_cmd_o=1 -> sd_cmd_o=1 from cycle 1 until done, p_ack_o=01 once, then IDLE.
REQ-034 Burst read, ReadBurstLength=4: port1 read addr=0x1000000; four sd_rvalid_i beats 0x0001..0x0004 -> p_rvalid_o=10 four times with matching data, sd_cmd_o=0 after first beat, p_ack_o=10 on beat 4.
REQ-035 Contention: both ports request continuously after reset -> grants alternate port0, port1, port0, port1 with one IDLE cycle between each, no p_ack_o overlap.
REQ-036 Spurious response: sd_rvalid_i=1 and sd_wdone_i=1 while idle -> p_rvalid_o=00, p_ack_o=00, state stays IDLE.
REQ-037 Reset mid-read: rst_i high after beat 2 of 4, then beats 3 and 4 arrive -> no p_rvalid_o, no p_ack_o; next contention grants port 0 first.
